// File: rtl/result_reader_pkg.sv
// result_reader_pkg
// Shared definitions for the result read-back path. It holds the bus region
// codes decoded from araddr[31:28], the default layer1 result word count, the
// reader state enum and a region-hit helper.
package result_reader_pkg;

    // Bus region codes carried in araddr[31:28]
    localparam logic [3:0] REGION_PIXEL     = 4'b0001;
    localparam logic [3:0] REGION_WEIGHT    = 4'b0010;
    localparam logic [3:0] REGION_RESULT    = 4'b0011;
    localparam logic [3:0] REGION_BIAS      = 4'b0100;
    localparam logic [3:0] REGION_IMAGE_SET = 4'b0101;
    localparam logic [3:0] REGION_INTERRUPT = 4'b0110;

    // Number of layer1 result words (32x32x8)
    localparam logic [15:0] RESULT_NUM_DEFAULT = 16'd8192;

    localparam int COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        R_IDLE,
        R_ADDR,
        R_MEM,
        R_CAP,
        R_RESP,
        R_FINISH
    } result_state_t;

    // Only the region nibble selects the result block; the low bits are
    // ignored because reads are sequential from an internal counter.
    function automatic logic is_result_hit(input logic [31:0] addr);
        return addr[31:28] == REGION_RESULT;
    endfunction

endpackage

// File: rtl/result_reader_counter.sv
// result_reader_counter
// Word sequence counter with a keep/clear interface.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   keep     : 1 holds the current value, 0 advances by one
//   clear    : synchronous clear to zero, takes priority over keep
//   count    : current count; it saturates at all-ones and never wraps
module result_reader_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             keep,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!keep && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/result_reader.sv
// result_reader
// Serves layer1 results to a bus read channel. Each accepted read in the
// result region returns the next result word, sign-extended to 32 bits. After
// RESULT_NUM words the block reports done. Further reads return zero until
// result_restart is pulsed.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   araddr/arvalid/arready      : read-address channel (region in [31:28])
//   rdata/rvalid/rready         : read-data channel
//   layer1_result_ready         : result memory stable, sampled in idle only
//   result_restart              : return from finish to idle
//   read_result_mem/result_mem_addr/result_mem_data : result memory port
//   result_read_done            : all words delivered
module result_reader
    import result_reader_pkg::*;
#(
    parameter logic [15:0] RESULT_NUM = RESULT_NUM_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    input  logic        layer1_result_ready,
    input  logic        result_restart,
    output logic        read_result_mem,
    output logic [15:0] result_mem_addr,
    input  logic [15:0] result_mem_data,
    output logic        result_read_done
);

    result_state_t state;
    logic [COUNT_WIDTH-1:0] count;
    logic hit;
    logic word_handshake;
    logic last_word;

    assign hit = is_result_hit(araddr);

    // arready must follow araddr in the same cycle, so it is decoded from
    // state. In finish it stays low while a zero response is pending.
    assign arready = hit && ((state == R_ADDR) ||
                             ((state == R_FINISH) && !rvalid));

    assign word_handshake = (state == R_RESP) && rvalid && rready;

    // The compare uses the post-increment count
    assign last_word = (count + 16'd1) == RESULT_NUM;

    result_reader_counter #(
        .WIDTH(COUNT_WIDTH)
    ) result_read_counter (
        .clk   (clk),
        .rst   (rst),
        .keep  (!word_handshake),
        .clear (word_handshake && last_word),
        .count (count)
    );

    // Reader FSM. The memory strobe and address are single-cycle pulses
    // issued on the address accept, so they are valid during R_MEM only.
    // The memory answers one cycle later, and R_CAP captures that data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= R_IDLE;
            rdata            <= '0;
            rvalid           <= 1'b0;
            read_result_mem  <= 1'b0;
            result_mem_addr  <= '0;
            result_read_done <= 1'b0;
        end else begin
            read_result_mem <= 1'b0;
            result_mem_addr <= '0;
            case (state)
                R_IDLE: begin
                    if (layer1_result_ready) begin
                        state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (arvalid && hit) begin
                        state           <= R_MEM;
                        read_result_mem <= 1'b1;
                        result_mem_addr <= count;
                    end
                end
                R_MEM: begin
                    state <= R_CAP;
                end
                R_CAP: begin
                    rdata  <= {{16{result_mem_data[15]}}, result_mem_data};
                    rvalid <= 1'b1;
                    state  <= R_RESP;
                end
                R_RESP: begin
                    if (rvalid && rready) begin
                        rvalid <= 1'b0;
                        if (last_word) begin
                            state            <= R_FINISH;
                            result_read_done <= 1'b1;
                        end else begin
                            state <= R_ADDR;
                        end
                    end
                end
                R_FINISH: begin
                    if (result_restart) begin
                        state            <= R_IDLE;
                        result_read_done <= 1'b0;
                        rvalid           <= 1'b0;
                    end else if (rvalid) begin
                        if (rready) begin
                            rvalid <= 1'b0;
                        end
                    end else if (arvalid && hit) begin
                        rdata  <= '0;
                        rvalid <= 1'b1;
                    end
                end
                default: begin
                    state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
